// File: rtl/tx9_pkg.sv
// Shared types for the envelope-triggered power/TX scheduler: FSM states,
// round-robin pointer encoding, default word width and the arbitration helper.
package tx9_pkg;

  localparam int DATA_W_DEF = 9;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    SETTLE = 2'd1,
    ARB    = 2'd2,
    SEND   = 2'd3
  } state_t;

  // Pointer records who was granted last; the other side wins a tie.
  localparam logic RR_A_LAST = 1'b0;
  localparam logic RR_B_LAST = 1'b1;

  function automatic logic pick_b(input logic req_a, input logic req_b, input logic rr_last);
    return req_b && (!req_a || (rr_last == RR_A_LAST));
  endfunction

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchronizer for an asynchronous pin with a registered rising-edge pulse.
// Pin to rise pulse takes three clock edges; q_sync is the synchronized level.
module sync_rise (
  input  logic CLK,
  input  logic RST,
  input  logic d_async,
  output logic q_sync,
  output logic rise
);

  logic meta;
  logic prev;

  always_ff @(posedge CLK) begin
    if (RST) begin
      meta   <= 1'b0;
      q_sync <= 1'b0;
      prev   <= 1'b0;
      rise   <= 1'b0;
    end else begin
      meta   <= d_async;
      q_sync <= meta;
      prev   <= q_sync;
      rise   <= q_sync && !prev;
    end
  end

endmodule

// File: rtl/tx9_pwr_scheduler.sv
// Envelope-triggered power sequencer feeding a 9-bit serializer from two round-robin
// requesters; one word per grant, held until tx_ready, power dropped after idle timeout.
module tx9_pwr_scheduler
  import tx9_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int PWR_SETTLE   = 1000,
  parameter int IDLE_TIMEOUT = 4096
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ENV_DET,
  input  logic              req_a,
  input  logic [DATA_W-1:0] data_a,
  output logic              gnt_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              gnt_b,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready,
  output logic              pwr_en,
  output logic              busy
);

  localparam int SET_W = $clog2(PWR_SETTLE + 1);
  localparam int IDL_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(PWR_SETTLE - 1);
  localparam logic [IDL_W-1:0] IDLE_LAST   = IDL_W'(IDLE_TIMEOUT - 1);

  state_t           state;
  logic             rr_last;
  logic [SET_W-1:0] settle_cnt;
  logic [IDL_W-1:0] idle_cnt;
  logic             env_sync;
  logic             env_rise;
  logic             win_b;

  sync_rise u_env_sync (
    .CLK     (CLK),
    .RST     (RST),
    .d_async (ENV_DET),
    .q_sync  (env_sync),
    .rise    (env_rise)
  );

  assign win_b = pick_b(req_a, req_b, rr_last);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= OFF;
      pwr_en     <= 1'b0;
      busy       <= 1'b0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      gnt_a      <= 1'b0;
      gnt_b      <= 1'b0;
      rr_last    <= RR_B_LAST;
      settle_cnt <= '0;
      idle_cnt   <= '0;
    end else begin
      gnt_a <= 1'b0;
      gnt_b <= 1'b0;
      case (state)
        OFF: begin
          if (env_rise) begin
            state      <= SETTLE;
            settle_cnt <= SETTLE_LOAD;
            pwr_en     <= 1'b1;
            busy       <= 1'b1;
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) state <= ARB;
          else settle_cnt <= settle_cnt - 1'b1;
        end
        ARB: begin
          if (req_a || req_b) begin
            tx_data  <= win_b ? data_b : data_a;
            tx_valid <= 1'b1;
            gnt_a    <= !win_b;
            gnt_b    <= win_b;
            rr_last  <= win_b ? RR_B_LAST : RR_A_LAST;
            state    <= SEND;
          end else if (env_sync) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IDLE_LAST) begin
            // Counter restarts so the next power-up gets a full idle window.
            state    <= OFF;
            pwr_en   <= 1'b0;
            busy     <= 1'b0;
            tx_valid <= 1'b0;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            idle_cnt <= '0;
            state    <= ARB;
          end
        end
        default: state <= OFF;
      endcase
    end
  end

endmodule
